// File: rtl/mips_pkg.sv
// Shared MIPS definitions: funct codes used by the decoder, ALU and HI/LO unit,
// plus the HI/LO unit state encoding.
package mips_pkg;

  localparam int unsigned FUNCT_W = 6;

  localparam logic [FUNCT_W-1:0] FN_MFHI  = 6'b010000;
  localparam logic [FUNCT_W-1:0] FN_MTHI  = 6'b010001;
  localparam logic [FUNCT_W-1:0] FN_MFLO  = 6'b010010;
  localparam logic [FUNCT_W-1:0] FN_MTLO  = 6'b010011;
  localparam logic [FUNCT_W-1:0] FN_MULT  = 6'b011000;
  localparam logic [FUNCT_W-1:0] FN_MULTU = 6'b011001;
  localparam logic [FUNCT_W-1:0] FN_DIV   = 6'b011010;
  localparam logic [FUNCT_W-1:0] FN_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } hilo_state_t;

endpackage

// File: rtl/hilo_if.sv
// Request/response bundle between the execute stage (master) and the HI/LO unit (slave).
interface hilo_if #(parameter int unsigned WIDTH = 32);
  import mips_pkg::*;

  logic               start;
  logic [FUNCT_W-1:0] op;
  logic [WIDTH-1:0]   rs_val;
  logic [WIDTH-1:0]   rt_val;
  logic               flush;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;

  modport master (output start, op, rs_val, rt_val, flush,
                  input  busy, done, hi, lo);
  modport slave  (input  start, op, rs_val, rt_val, flush,
                  output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_core.sv
// Unsigned iterative engine: one shift-add (multiply) or restoring
// shift-subtract (divide) step per cycle, WIDTH steps per operation.
module muldiv_core #(parameter int unsigned WIDTH = 32) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic               i_is_div,
  input  logic               i_run,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic               o_last_c,
  output logic [2*WIDTH-1:0] o_prod,
  output logic [WIDTH-1:0]   o_quot,
  output logic [WIDTH-1:0]   o_rem
);
  localparam int unsigned CW = $clog2(WIDTH);

  logic [CW-1:0]      r_cnt;
  logic               r_is_div;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_quot;
  logic [WIDTH-1:0]   r_rem;

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_diff;

  // Multiplier sits in the low half of the accumulator and shifts out LSB first.
  assign w_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_a & {WIDTH{r_acc[0]}}};
  assign w_shift = {r_rem, r_quot[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, r_b};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_quot   <= '0;
      r_rem    <= '0;
    end else if (i_start) begin
      r_cnt    <= '0;
      r_is_div <= i_is_div;
      r_a      <= i_a;
      r_b      <= i_b;
      r_acc    <= {WIDTH'(0), i_b};
      r_quot   <= i_a;
      r_rem    <= '0;
    end else if (i_run) begin
      r_cnt <= r_cnt + CW'(1);
      if (r_is_div) begin
        // Borrow out of the trial subtract means restore (keep the shifted value).
        if (!w_diff[WIDTH]) begin
          r_rem  <= w_diff[WIDTH-1:0];
          r_quot <= {r_quot[WIDTH-2:0], 1'b1};
        end else begin
          r_rem  <= w_shift[WIDTH-1:0];
          r_quot <= {r_quot[WIDTH-2:0], 1'b0};
        end
      end else begin
        r_acc <= {w_sum, r_acc[WIDTH-1:1]};
      end
    end
  end

  assign o_last_c = (r_cnt == CW'(WIDTH - 1));
  assign o_prod   = r_acc;
  assign o_quot   = r_quot;
  assign o_rem    = r_rem;

endmodule

// File: rtl/hilo_unit.sv
// HI/LO register pair with sequential MULT/MULTU/DIV/DIVU and MTHI/MTLO.
// Operands are reduced to magnitudes; signs are reapplied in the FIX cycle.
module hilo_unit #(parameter int unsigned WIDTH = 32) (
  input  logic   clk,
  input  logic   rst,
  hilo_if.slave  bus
);
  import mips_pkg::*;

  localparam int unsigned W = WIDTH;

  hilo_state_t    r_state, w_state_nxt;
  logic [W-1:0]   r_hi, r_lo, w_hi_nxt, w_lo_nxt;
  logic           r_done, r_busy, w_done_nxt;
  logic           r_is_div, r_neg_q, r_neg_r, r_dz;
  logic [W-1:0]   r_rs_raw;

  logic           w_core_start, w_core_run, w_last_c;
  logic           w_is_mul, w_is_div, w_signed, w_rs_neg, w_rt_neg;
  logic [W-1:0]   w_rs_mag, w_rt_mag, w_quot, w_rem, w_quot_s, w_rem_s;
  logic [2*W-1:0] w_prod, w_prod_s;

  assign w_is_mul = (bus.op == FN_MULT) || (bus.op == FN_MULTU);
  assign w_is_div = (bus.op == FN_DIV)  || (bus.op == FN_DIVU);
  assign w_signed = (bus.op == FN_MULT) || (bus.op == FN_DIV);
  assign w_rs_neg = w_signed & bus.rs_val[W-1];
  assign w_rt_neg = w_signed & bus.rt_val[W-1];
  assign w_rs_mag = w_rs_neg ? -bus.rs_val : bus.rs_val;
  assign w_rt_mag = w_rt_neg ? -bus.rt_val : bus.rt_val;

  muldiv_core #(.WIDTH(W)) u_core (
    .clk      (clk),
    .rst      (rst),
    .i_start  (w_core_start),
    .i_is_div (w_is_div),
    .i_run    (w_core_run),
    .i_a      (w_rs_mag),
    .i_b      (w_rt_mag),
    .o_last_c (w_last_c),
    .o_prod   (w_prod),
    .o_quot   (w_quot),
    .o_rem    (w_rem)
  );

  assign w_prod_s = r_neg_q ? -w_prod : w_prod;
  assign w_quot_s = r_neg_q ? -w_quot : w_quot;
  assign w_rem_s  = r_neg_r ? -w_rem  : w_rem;

  // Next-state and HI/LO write selection.
  always_comb begin
    w_state_nxt  = r_state;
    w_hi_nxt     = r_hi;
    w_lo_nxt     = r_lo;
    w_done_nxt   = 1'b0;
    w_core_start = 1'b0;
    w_core_run   = 1'b0;
    if (bus.flush) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            if (w_is_mul) begin
              w_state_nxt  = ST_MUL;
              w_core_start = 1'b1;
            end else if (w_is_div) begin
              w_state_nxt  = ST_DIV;
              w_core_start = 1'b1;
            end else if (bus.op == FN_MTHI) begin
              w_hi_nxt   = bus.rs_val;
              w_done_nxt = 1'b1;
            end else if (bus.op == FN_MTLO) begin
              w_lo_nxt   = bus.rs_val;
              w_done_nxt = 1'b1;
            end
          end
        end
        ST_MUL, ST_DIV: begin
          w_core_run = 1'b1;
          if (w_last_c) w_state_nxt = ST_FIX;
        end
        ST_FIX: begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
          if (r_is_div && r_dz) begin
            w_hi_nxt = r_rs_raw;
            w_lo_nxt = '1;
          end else if (r_is_div) begin
            w_hi_nxt = w_rem_s;
            w_lo_nxt = w_quot_s;
          end else begin
            w_hi_nxt = w_prod_s[2*W-1:W];
            w_lo_nxt = w_prod_s[W-1:0];
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dz     <= 1'b0;
      r_rs_raw <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_hi    <= w_hi_nxt;
      r_lo    <= w_lo_nxt;
      r_done  <= w_done_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
      if (w_core_start) begin
        r_is_div <= w_is_div;
        r_neg_q  <= w_rs_neg ^ w_rt_neg;
        r_neg_r  <= w_rs_neg;
        r_dz     <= (bus.rt_val == '0);
        r_rs_raw <= bus.rs_val;
      end
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;

endmodule

// File: doc/hilo_unit.md
# hilo_unit

Sequential multiply/divide unit and HI/LO register pair for the MIPS pipeline. It sits beside the execute-stage ALU and accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO requests. It computes products and quotients iteratively over a fixed latency and holds the results in architectural HI/LO registers. The pipeline reads `hi`/`lo` directly for MFHI/MFLO and stalls on `busy`.

## Interface
- `WIDTH`, 32: operand and HI/LO register width. Iteration count equals `WIDTH`.
- `clk`  in  1: rising-edge clock.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: request valid. Accepted only when `busy`=0 and `flush`=0.
- `op`  in  6: funct code. MULT 011000, MULTU 011001, DIV 011010, DIVU 011011, MTHI 010001, MTLO 010011. Any other code with `start` is ignored.
- `rs_val`  in  WIDTH: multiplicand, dividend, or MTHI/MTLO source.
- `rt_val`  in  WIDTH: multiplier or divisor.
- `flush`  in  1: abort the in-flight operation.
- `busy`  out  1: high while state≠IDLE. Reset 0.
- `done`  out  1: one-cycle pulse when HI/LO are written. Reset 0.
- `hi`  out  WIDTH: HI register. Reset 0.
- `lo`  out  WIDTH: LO register. Reset 0.

## Operation
- States: IDLE, MUL, DIV, FIX. A counter `cnt` (log2 WIDTH bits) tracks iterations.
- IDLE with an accepted MUL/DIV op:
  - Latch |rs|, |rt|, op, result sign, and a divide-by-zero flag (rt==0).
  - Unsigned ops take operand magnitudes as-is.
  - Go to MUL or DIV with cnt=0.
- MUL: one shift-add step per cycle into a 2·WIDTH accumulator.
- DIV: one restoring shift-subtract step per cycle (quotient and remainder registers).
- Exit: after cnt=WIDTH-1, go to FIX.
- FIX (one cycle, always taken so latency is fixed), then IDLE:
  - Write hi/lo. Pulse `done` the following cycle.
  - Signed MULT: negate the 64-bit product if sign(rs)^sign(rt).
  - Signed DIV: negate the quotient if sign(rs)^sign(rt); negate the remainder if sign(rs).
  - hi=remainder/product[63:32]; lo=quotient/product[31:0].
- Divide by zero (DIV or DIVU): FIX forces hi=rs_val as latched, lo=32'hFFFF_FFFF.
- DIV 0x8000_0000 / 0xFFFF_FFFF: lo=0x8000_0000, hi=0. This falls out of the magnitude path; no trap.
- MTHI/MTLO in IDLE: write hi (or lo) with rs_val at the next edge. State stays IDLE; `done` pulses that cycle.
- `start` while busy: ignored. The pipeline must hold the request until busy=0.
- `flush`: state goes to IDLE at the next edge. hi/lo unchanged, no `done`. Flush wins over a simultaneous `start`.
- Reset mid-operation: immediate clear of state, cnt, hi, lo, busy, and done.

## Timing
- Start accepted at edge 0 (cycle 0 is the request cycle).
- MUL/DIV: cycles 1–32; FIX: cycle 33. `busy`=1 in cycles 1–33.
- hi/lo updated at the edge ending cycle 33. `done`=1 and `busy`=0 in cycle 34.
- A new `start` is accepted in cycle 34. Back-to-back ops therefore have a 34-cycle throughput.
- MTHI/MTLO: hi/lo updated at edge 0; `done` in cycle 1; `busy` never asserted.
- `hi`/`lo` are register outputs with no combinational path from inputs.

## Structure
- Shared package `mips_pkg` holds:
  - Funct-code localparams shared with the ALU and the decoder: MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO.
  - The `hilo_state_t` enum (IDLE, MUL, DIV, FIX).
- One sub-module, `muldiv_core`: the unsigned iterative engine (accumulator, quotient, and remainder registers plus cnt), with start/op inputs and a last-iteration flag.
- `hilo_unit` wraps `muldiv_core` and owns the FSM, sign handling, the divide-by-zero override, and the HI/LO registers.

## Test plan
- MULTU 0xFFFF_FFFF × 0xFFFF_FFFF → cycle 34: hi=0xFFFF_FFFE, lo=0x0000_0001, done=1, busy low.
- MULT 0xFFFF_FFFD (−3) × 7 → hi=0xFFFF_FFFF, lo=0xFFFF_FFEB.
- DIV −7/2 → lo=0xFFFF_FFFD, hi=0xFFFF_FFFF. DIVU 7/2 → lo=3, hi=1.
- DIV 0x8000_0000/−1 → lo=0x8000_0000, hi=0.
- DIVU 0x1234_5678/0 → hi=0x1234_5678, lo=0xFFFF_FFFF, still at cycle 34.
- MTHI 0xDEAD_BEEF → hi updated at cycle 1, done pulse.
- Issue MULT; in cycle 10 pulse `start` with DIVU (ignored), then assert `flush` → busy=0 next cycle, hi/lo retain prior values, no done.
- Repeat with `rst` asserted in cycle 10 → all outputs 0 immediately.
